// File: rtl/ffsr_pulse_driver.sv
// Pulse-stream transmitter: walks a saturating up/down counter receiver to a requested
// value with single-cycle inc/dec pulses, tracking the receiver value in a local shadow.
module ffsr_pulse_driver #(
  parameter int WIDTH = 3,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] target,
  input  logic             req,
  input  logic             abort,
  output logic             ready,
  output logic             inc,
  output logic             dec,
  output logic             done,
  output logic [WIDTH-1:0] shadow
);

  // state | meaning
  // IDLE  | waiting for a request, ready high
  // PULSE | inc or dec high this cycle
  // WAIT  | GAP idle cycles between pulses
  // DONE  | done strobe high for one cycle
  typedef enum logic [1:0] {IDLE, PULSE, WAIT, DONE} state_t;

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [3:0]       GAP_LD  = 4'(GAP);

  state_t           state;
  logic [WIDTH-1:0] tgt;
  logic [3:0]       gap_cnt;
  logic [WIDTH-1:0] shadow_nxt;

  // Receiver value after the current edge, including its saturation.
  always_comb begin
    shadow_nxt = shadow;
    if (inc && shadow != MAX_VAL)
      shadow_nxt = shadow + 1'b1;
    else if (dec && shadow != '0)
      shadow_nxt = shadow - 1'b1;
  end

  assign ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shadow  <= '0;
      tgt     <= '0;
      gap_cnt <= '0;
      inc     <= 1'b0;
      dec     <= 1'b0;
      done    <= 1'b0;
    end else begin
      shadow <= shadow_nxt;
      inc    <= 1'b0;
      dec    <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            tgt <= target;
            if (target == shadow) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= PULSE;
              inc   <= (shadow < target);
              dec   <= (shadow > target);
            end
          end
        end
        PULSE: begin
          if (abort || shadow_nxt == tgt) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (GAP > 0) begin
            state   <= WAIT;
            gap_cnt <= GAP_LD;
          end else begin
            inc <= (shadow_nxt < tgt);
            dec <= (shadow_nxt > tgt);
          end
        end
        WAIT: begin
          if (abort) begin
            state   <= DONE;
            done    <= 1'b1;
            gap_cnt <= '0;
          end else if (gap_cnt <= 4'd1) begin
            state   <= PULSE;
            gap_cnt <= '0;
            inc     <= (shadow < tgt);
            dec     <= (shadow > tgt);
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ffsr_pulse_driver.sv
// Bench for ffsr_pulse_driver: three instances with different GAP, each driving a receiver
// model; per-cycle expectations come from the pulse schedule arithmetic.
module tb_ffsr_pulse_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req_v   = '0;
  logic [2:0] abort_v = '0;
  logic [2:0] inc_v, dec_v, done_v, ready_v;
  logic [2:0] tgt_v [3];
  logic [2:0] sh_v  [3];
  logic [2:0] rx    [3];
  int         mv    [3];
  int         checks = 0;
  int         errors = 0;
  logic       mon_en = 1'b0;

  always #5 clk = ~clk;

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 2 : 3;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ffsr_pulse_driver #(.WIDTH(3), .GAP((g == 0) ? 0 : (g == 1) ? 2 : 3)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .target (tgt_v[g]),
      .req    (req_v[g]),
      .abort  (abort_v[g]),
      .ready  (ready_v[g]),
      .inc    (inc_v[g]),
      .dec    (dec_v[g]),
      .done   (done_v[g]),
      .shadow (sh_v[g])
    );
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Receiver: saturating counter fed by the pulses, reset by the same rst.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rst) rx[g] <= 3'd0;
      else if (inc_v[g] && rx[g] != 3'd7) rx[g] <= rx[g] + 3'd1;
      else if (dec_v[g] && rx[g] != 3'd0) rx[g] <= rx[g] - 3'd1;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("rx_eq_shadow[%0d]", g), {5'd0, sh_v[g]}, {5'd0, rx[g]});
        chk($sformatf("inc_dec_excl[%0d]", g), {7'd0, inc_v[g] & dec_v[g]}, 8'd0);
      end
    end
  end

  // Called just after a negedge with instance i idle; returns at the negedge of the
  // cycle in which ready is back high. ab/sp: cycle of abort / spurious req, -1 for none.
  task automatic run(input int i, input int t, input int ab, input int sp);
    int g, n, up, d, np, dx, base, prev, pulse, exp_sh;
    g = gap_of(i);
    base = mv[i];
    up = (t > base) ? 1 : 0;
    n = up ? t - base : base - t;
    d = (n == 0) ? 1 : 1 + (n - 1) * (g + 1) + 1;
    np = n;
    dx = d;
    if (ab >= 1 && ab < d && n > 0) begin
      np = (ab - 1) / (g + 1) + 1;
      if (np > n) np = n;
      dx = ab + 1;
    end
    chk($sformatf("ready_c0[%0d]", i), {7'd0, ready_v[i]}, 8'd1);
    chk($sformatf("shadow_c0[%0d]", i), {5'd0, sh_v[i]}, 8'(base));
    req_v[i] = 1'b1;
    tgt_v[i] = 3'(t);
    @(negedge clk);
    for (int c = 1; c <= dx + 1; c++) begin
      req_v[i] = 1'b0;
      abort_v[i] = 1'b0;
      pulse = (c < dx && ((c - 1) % (g + 1)) == 0 && ((c - 1) / (g + 1)) < np) ? 1 : 0;
      prev = (c == 1) ? 0 : ((c - 2) / (g + 1) + 1);
      if (prev > np) prev = np;
      exp_sh = up ? base + prev : base - prev;
      chk($sformatf("inc[%0d] c%0d t%0d", i, c, t), {7'd0, inc_v[i]}, 8'(pulse & up));
      chk($sformatf("dec[%0d] c%0d t%0d", i, c, t), {7'd0, dec_v[i]}, 8'(pulse & (1 - up)));
      chk($sformatf("done[%0d] c%0d t%0d", i, c, t), {7'd0, done_v[i]}, 8'(c == dx));
      chk($sformatf("ready[%0d] c%0d t%0d", i, c, t), {7'd0, ready_v[i]}, 8'(c == dx + 1));
      chk($sformatf("shadow[%0d] c%0d t%0d", i, c, t), {5'd0, sh_v[i]}, 8'(exp_sh));
      if (c <= dx) begin
        if (c == ab) abort_v[i] = 1'b1;
        if (c == sp) begin
          req_v[i] = 1'b1;
          tgt_v[i] = 3'd0;
        end
        @(negedge clk);
      end
    end
    mv[i] = up ? base + np : base - np;
  endtask

  initial begin
    int i, t, ab, sp;
    for (int g = 0; g < 3; g++) begin
      tgt_v[g] = 3'd0;
      mv[g] = 0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst_ready[%0d]", g), {7'd0, ready_v[g]}, 8'd1);
      chk($sformatf("rst_inc[%0d]", g), {7'd0, inc_v[g]}, 8'd0);
      chk($sformatf("rst_dec[%0d]", g), {7'd0, dec_v[g]}, 8'd0);
      chk($sformatf("rst_done[%0d]", g), {7'd0, done_v[g]}, 8'd0);
      chk($sformatf("rst_shadow[%0d]", g), {5'd0, sh_v[g]}, 8'd0);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    run(0, 5, -1, -1);
    run(0, 2, -1, -1);
    run(0, 3, -1, -1);
    run(0, 3, -1, -1);
    run(1, 3, -1, -1);
    run(0, 0, -1, -1);
    run(0, 7, -1, 3);
    run(0, 0, -1, -1);
    run(0, 7, 3, -1);
    run(1, 7, 5, 2);

    // Reset in cycle 2 of a 0->6 train.
    run(0, 0, -1, -1);
    req_v[0] = 1'b1;
    tgt_v[0] = 3'd6;
    @(negedge clk);
    req_v[0] = 1'b0;
    chk("mrst_inc_c1", {7'd0, inc_v[0]}, 8'd1);
    @(negedge clk);
    chk("mrst_shadow_c2", {5'd0, sh_v[0]}, 8'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_shadow", {5'd0, sh_v[0]}, 8'd0);
    chk("mrst_inc", {7'd0, inc_v[0]}, 8'd0);
    chk("mrst_ready", {7'd0, ready_v[0]}, 8'd1);
    chk("mrst_done", {7'd0, done_v[0]}, 8'd0);
    for (int g = 0; g < 3; g++) mv[g] = 0;
    repeat (3) begin
      @(negedge clk);
      chk("mrst_done_after", {7'd0, done_v[0]}, 8'd0);
      chk("mrst_ready_after", {7'd0, ready_v[0]}, 8'd1);
    end

    for (int g = 0; g < 3; g++) begin
      run(g, 0, -1, -1);
      run(g, 7, -1, -1);
      run(g, 0, -1, -1);
    end

    for (int k = 0; k < 60; k++) begin
      i = $urandom_range(0, 2);
      t = $urandom_range(0, 7);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : -1;
      sp = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : -1;
      run(i, t, ab, sp);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ffsr_pulse_driver.md
# ffsr_pulse_driver

Pulse-stream transmitter for the saturating binary pulse counter receiver used in the FFSR datapath. It accepts a target value over a ready/req handshake and emits a train of single-cycle `inc` or `dec` pulses that walk the receiver from its current value to the target. An internal shadow register mirrors the receiver's value cycle-for-cycle, so no readback path is needed. A `done` strobe marks completion, and an abort input stops the train early.

## Interface
- `WIDTH`, default 3: value width. Must match the receiver width.
- `GAP`, default 0: number of idle cycles inserted between consecutive pulses. 0 means back-to-back pulses. Legal range 0..15.

- `clk`  input  1  clock; all state changes on the rising edge
- `rst`  input  1  one clock; reset is synchronous and active-high
- `target`  input  WIDTH  requested receiver value; sampled only on an accepted request
- `req`  input  1  request strobe; accepted when `req` and `ready` are both high at a clock edge
- `abort`  input  1  stop the current pulse train
- `ready`  output  1  high only in IDLE
- `inc`  output  1  registered increment pulse to the receiver
- `dec`  output  1  registered decrement pulse to the receiver
- `done`  output  1  one-cycle completion strobe
- `shadow`  output  WIDTH  value the receiver holds after the current edge

## Operation
- **States:** IDLE, PULSE, WAIT, DONE.
- **IDLE**
  - `ready`=1.
  - On an accepted `req`, latch `target` into `tgt`.
  - If `tgt`==`shadow`, go to DONE (no pulses).
  - Otherwise go to PULSE.
- **PULSE** (exactly one cycle)
  - Assert `inc`=1 if `shadow`<`tgt`, else `dec`=1.
  - `shadow` updates at the edge ending this cycle: +1 for `inc`, -1 for `dec`.
  - After the update, if `shadow` equals `tgt`, go to DONE.
  - Otherwise go to WAIT if GAP>0 (gap counter loaded with GAP), or to PULSE if GAP=0.
- **WAIT**
  - `inc`=`dec`=0.
  - Decrement the gap counter each cycle; go to PULSE when it expires after GAP cycles.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
- **abort** (sampled in PULSE or WAIT)
  - The pulse issued in the same cycle still counts, and `shadow` stays consistent with it.
  - Next state is DONE regardless of distance to target.
  - `abort` is ignored in IDLE and DONE.
- **req handling:** `req` while `ready`=0 is ignored; it is neither queued nor latched.
- **Pulse exclusivity:** `inc` and `dec` are never high in the same cycle.
- **Arithmetic:** `shadow` is unsigned WIDTH bits. It saturates at 0 and 2^WIDTH-1. Saturation cannot be reached in normal operation because `tgt` is always in range.
- **Comparisons:** unsigned, WIDTH bits.
- **Reset:** assertion at any point, including mid-train, forces the following values at the next edge:
  - state IDLE
  - `shadow`=0, `tgt`=0, gap counter 0
  - `inc`=`dec`=`done`=0, `ready`=1
- **System reset:** the system drives the same `rst` into the receiver, so both sides restart at 0.

## Timing
- **Cycle numbering:** `req` accepted at the edge ending cycle 0. Let N = |`tgt` - `shadow`|.
- **First pulse:** high during cycle 1.
- **Pulse k** (k = 1..N): high during cycle 1+(k-1)(GAP+1).
- **`done`:** high in the cycle after the last pulse, i.e. cycle 1+(N-1)(GAP+1)+1.
- **`ready`:** returns high the cycle after `done`.
- **N=0:** `done` in cycle 1, `ready` in cycle 2, no pulses.
- **Minimum request-to-request spacing:** N(GAP+1)-GAP+2 cycles.
- **`shadow` alignment:** `shadow` changes at the same edge at which the receiver consumes the pulse. The two values are equal in every cycle.
- **Output registration:** `inc`, `dec` and `done` are registered. `ready` decodes state directly, with no combinational path from `req`.

## Test plan
- **Increment train:** reset, GAP=0, `target`=5 -> `inc` high cycles 1–5; `shadow` steps 1,2,3,4,5; `done` cycle 6; `ready` cycle 7.
- **Decrement train:** from `shadow`=5, `target`=2 -> `dec` high cycles 1–3; `shadow` 4,3,2; `done` cycle 4; `inc` never high.
- **Equal target:** `target` equal to `shadow` (3) -> no pulses; `done` cycle 1. Then GAP=2, from 0, `target`=3 -> `inc` in cycles 1, 4, 7; `done` cycle 8.
- **Handshake and abort:** `req` with `target`=0 during an active train toward 7 -> ignored, train continues. `abort` in cycle 3 of 0->7 -> pulses in cycles 1–3, `shadow`=3, `done` cycle 4.
- **Reset mid-train:** `rst` asserted in cycle 2 of 0->6 -> next edge gives `shadow`=0, `inc`=0, `ready`=1, `done` never pulses.
- **Full-scale with receiver:** receiver model connected, random targets 0..7 with random GAP and random aborts -> receiver value equals `shadow` every cycle and `inc`&`dec` is never 1. Includes 0->7->0 full-scale sweeps.
